// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// phase_sequencer_if
//   Bundles the control/write inputs and the phase stream outputs of
//   phase_sequencer. Clock and reset stay plain ports on the module.
//
//   master : control side (drives tick/writes/clear, observes results)
//   slave  : the sequencer itself
//
//   i_SampleTick      one-cycle pulse that starts a pass
//   i_WriteEnable     frequency write strobe
//   i_WriteVoice      voice addressed by the write
//   i_WriteFrequency  new frequency word (2^-8 Hz units)
//   i_WriteKeyOn      arm a one-shot phase clear for the written voice
//   i_ClearOverrun    clears the sticky overrun flag
//   o_Busy            pass in progress
//   o_PhaseValid      o_Voice/o_Phase carry a fresh result this cycle
//   o_Voice           voice index of o_Phase
//   o_Phase           updated phase of o_Voice
//   o_Overrun         sticky: a tick arrived while busy
// ---------------------------------------------------------------------------
interface phase_sequencer_if #(
    parameter int NUM_VOICES  = 32,
    parameter int PHASE_WIDTH = 24
);
    localparam int VW = $clog2(NUM_VOICES);

    logic                   i_SampleTick;
    logic                   i_WriteEnable;
    logic [VW-1:0]          i_WriteVoice;
    logic [PHASE_WIDTH-1:0] i_WriteFrequency;
    logic                   i_WriteKeyOn;
    logic                   i_ClearOverrun;
    logic                   o_Busy;
    logic                   o_PhaseValid;
    logic [VW-1:0]          o_Voice;
    logic [PHASE_WIDTH-1:0] o_Phase;
    logic                   o_Overrun;

    modport master (
        output i_SampleTick, i_WriteEnable, i_WriteVoice, i_WriteFrequency,
               i_WriteKeyOn, i_ClearOverrun,
        input  o_Busy, o_PhaseValid, o_Voice, o_Phase, o_Overrun
    );

    modport slave (
        input  i_SampleTick, i_WriteEnable, i_WriteVoice, i_WriteFrequency,
               i_WriteKeyOn, i_ClearOverrun,
        output o_Busy, o_PhaseValid, o_Voice, o_Phase, o_Overrun
    );
endinterface

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//   One shared phase adder time-multiplexed over NUM_VOICES voice slots.
//   A sample tick starts a pass that updates one voice per clock, in order,
//   streaming (voice, phase) results. Frequency / key-on writes are taken
//   every cycle; a write that hits the voice being updated takes effect on
//   the next pass.
//
//   i_Clock  : sole clock
//   i_Reset  : synchronous, active-high; aborts any pass, clears all voices
//   bus      : phase_sequencer_if.slave (tick, writes, overrun clear,
//              busy / phase stream / overrun outputs), all outputs registered
// ---------------------------------------------------------------------------
module phase_sequencer #(
    parameter int NUM_VOICES  = 32,
    parameter int PHASE_WIDTH = 24
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    phase_sequencer_if.slave   bus
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [VW-1:0]          v_q, v_d;
    logic [PHASE_WIDTH-1:0] freq_q  [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] freq_d  [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]  pending_q, pending_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [VW-1:0]          voice_q, voice_d;
    logic [PHASE_WIDTH-1:0] phase_out_q, phase_out_d;
    logic                   overrun_q, overrun_d;
    logic [PHASE_WIDTH-1:0] next_phase;

    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        v_d         = v_q;
        freq_d      = freq_q;
        phase_d     = phase_q;
        pending_d   = pending_q;
        valid_d     = 1'b0;
        voice_d     = voice_q;
        phase_out_d = phase_out_q;
        overrun_d   = overrun_q;
        next_phase  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_SampleTick) begin
                    state_d = S_RUN;
                    v_d     = '0;
                end
            end
            S_RUN: begin
                // A pending key-on wins over accumulation; carry is dropped.
                next_phase     = pending_q[v_q] ? '0 : phase_q[v_q] + freq_q[v_q];
                phase_d[v_q]   = next_phase;
                pending_d[v_q] = 1'b0;
                valid_d        = 1'b1;
                voice_d        = v_q;
                phase_out_d    = next_phase;
                if (v_q == LAST_VOICE) begin
                    state_d = S_IDLE;
                    v_d     = '0;
                end else begin
                    v_d = v_q + VW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                v_d     = '0;
            end
        endcase

        // Writes land after the update above, so a colliding write only
        // affects the next pass (old freq and old pending were used).
        if (bus.i_WriteEnable) begin
            freq_d[bus.i_WriteVoice] = bus.i_WriteFrequency;
            if (bus.i_WriteKeyOn) begin
                pending_d[bus.i_WriteVoice] = 1'b1;
            end
        end

        // Set beats clear when both happen in the same cycle.
        if (bus.i_ClearOverrun) begin
            overrun_d = 1'b0;
        end
        if (bus.i_SampleTick && (state_q == S_RUN)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge i_Clock) begin
        // NOTE: the voice arrays are plain flops and are cleared on reset,
        // because a reset must silence every voice; this rules out RAM.
        if (i_Reset) begin
            state_q     <= S_IDLE;
            v_q         <= '0;
            freq_q      <= '{default: '0};
            phase_q     <= '{default: '0};
            pending_q   <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            voice_q     <= '0;
            phase_out_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            v_q         <= v_d;
            freq_q      <= freq_d;
            phase_q     <= phase_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            voice_q     <= voice_d;
            phase_out_q <= phase_out_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.o_Busy       = busy_q;
    assign bus.o_PhaseValid = valid_q;
    assign bus.o_Voice      = voice_q;
    assign bus.o_Phase      = phase_out_q;
    assign bus.o_Overrun    = overrun_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
//   Directed bench for phase_sequencer. A pass-level model (remaining-voice
//   count, integer phase arrays) predicts every output each cycle; literal
//   per-pass expectations pin the model.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;
    localparam int NV = 32;
    localparam int PW = 24;
    localparam int unsigned MASK = 32'h00FF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_sequencer_if #(.NUM_VOICES(NV), .PHASE_WIDTH(PW)) bus ();

    phase_sequencer #(.NUM_VOICES(NV), .PHASE_WIDTH(PW)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_freq [NV];
    int unsigned m_phase[NV];
    bit          m_pend [NV];
    int          m_remaining = 0;
    bit          m_armed = 0;
    bit          e_busy, e_valid, e_overrun;
    int unsigned e_voice, e_phase;
    bit          m_ovr_evt;
    int          m_k;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NV; i++) begin
                m_freq[i] = 0; m_phase[i] = 0; m_pend[i] = 0;
            end
            m_remaining = 0;
            e_busy = 0; e_valid = 0; e_overrun = 0; e_voice = 0; e_phase = 0;
        end else begin
            m_ovr_evt = bus.i_SampleTick && (m_remaining > 0);
            e_valid = 0;
            if (m_remaining > 0) begin
                m_k = NV - m_remaining;
                if (m_pend[m_k]) begin
                    m_phase[m_k] = 0;
                    m_pend[m_k]  = 0;
                end else begin
                    m_phase[m_k] = (m_phase[m_k] + m_freq[m_k]) & MASK;
                end
                e_valid = 1;
                e_voice = m_k;
                e_phase = m_phase[m_k];
                m_remaining--;
            end else if (bus.i_SampleTick) begin
                m_remaining = NV;
            end
            if (bus.i_WriteEnable) begin
                m_freq[bus.i_WriteVoice] = bus.i_WriteFrequency;
                if (bus.i_WriteKeyOn) m_pend[bus.i_WriteVoice] = 1;
            end
            if (bus.i_ClearOverrun) e_overrun = 0;
            if (m_ovr_evt) e_overrun = 1;
            e_busy = (m_remaining > 0);
        end
        m_armed = 1;
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_armed) begin
            check("busy",    bus.o_Busy,       e_busy);
            check("valid",   bus.o_PhaseValid, e_valid);
            check("overrun", bus.o_Overrun,    e_overrun);
            check("voice",   bus.o_Voice,      e_voice);
            check("phase",   bus.o_Phase,      e_phase);
        end
    end

    // Per-pass capture used by the literal expectations.
    logic [PW-1:0] pass_out[NV];
    int valid_cnt = 0;
    int busy_cnt  = 0;

    always @(negedge clk) begin
        if (bus.o_PhaseValid === 1'b1) begin
            pass_out[bus.o_Voice] = bus.o_Phase;
            valid_cnt++;
        end
        if (bus.o_Busy === 1'b1) busy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.i_SampleTick     = 1'b0;
        bus.i_WriteEnable    = 1'b0;
        bus.i_WriteVoice     = '0;
        bus.i_WriteFrequency = '0;
        bus.i_WriteKeyOn     = 1'b0;
        bus.i_ClearOverrun   = 1'b0;
        rst                  = 1'b0;
    endtask

    task automatic write_freq(input int v, input int unsigned f, input bit keyon);
        @(negedge clk);
        bus.i_WriteEnable    = 1'b1;
        bus.i_WriteVoice     = v[4:0];
        bus.i_WriteFrequency = f[PW-1:0];
        bus.i_WriteKeyOn     = keyon;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.i_ClearOverrun = 1'b1;
        @(negedge clk);
        bus.i_ClearOverrun = 1'b0;
        check("overrun_cleared", bus.o_Overrun, 1'b0);
    endtask

    // Starts a pass. Stimulus set at loop index c is sampled on the edge that
    // processes voice c. act_kind: 0 none, 1 collision write to voice 7,
    // 2 tick, 3 tick + clear overrun, 4 reset.
    task automatic run_pass(input int act_cycle, input int act_kind);
        valid_cnt = 0;
        busy_cnt  = 0;
        for (int i = 0; i < NV; i++) pass_out[i] = 'x;
        @(negedge clk);
        bus.i_SampleTick = 1'b1;
        @(negedge clk);
        bus.i_SampleTick = 1'b0;
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            if (act_kind == 4 && c == act_cycle + 1) begin
                check("reset_abort_valid", bus.o_PhaseValid, 1'b0);
                check("reset_abort_busy",  bus.o_Busy,       1'b0);
            end
            if (c == act_cycle) begin
                case (act_kind)
                    1: begin
                        bus.i_WriteEnable    = 1'b1;
                        bus.i_WriteVoice     = 5'd7;
                        bus.i_WriteFrequency = 24'h000020;
                        bus.i_WriteKeyOn     = 1'b1;
                    end
                    2: bus.i_SampleTick = 1'b1;
                    3: begin
                        bus.i_SampleTick   = 1'b1;
                        bus.i_ClearOverrun = 1'b1;
                    end
                    4: rst = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        idle_inputs();
        check("pass_terminated", bus.o_Busy, 1'b0);
    endtask

    function automatic int count_nonzero_except(input int skip);
        int n = 0;
        for (int i = 0; i < NV; i++)
            if (i != skip && pass_out[i] !== '0) n++;
        return n;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",    bus.o_Busy,       1'b0);
        check("rst_valid",   bus.o_PhaseValid, 1'b0);
        check("rst_phase",   bus.o_Phase,      24'h0);
        check("rst_overrun", bus.o_Overrun,    1'b0);
        rst = 1'b0;

        // All frequencies zero: 32 results, all zero.
        run_pass(-1, 0);
        check("t1_valid_cycles", valid_cnt, 32);
        check("t1_busy_cycles",  busy_cnt,  32);
        check("t1_nonzero",      count_nonzero_except(-1), 0);
        check("t1_overrun",      bus.o_Overrun, 1'b0);

        // Voice 3 accumulating 0x100 per pass.
        write_freq(3, 24'h000100, 1'b0);
        run_pass(-1, 0);
        check("t2_v3_p1", pass_out[3], 24'h000100);
        check("t2_others_p1", count_nonzero_except(3), 0);
        run_pass(-1, 0);
        check("t2_v3_p2", pass_out[3], 24'h000200);
        run_pass(-1, 0);
        check("t2_v3_p3", pass_out[3], 24'h000300);
        check("t2_others_p3", count_nonzero_except(3), 0);

        // Key-on between passes.
        write_freq(3, 24'h000100, 1'b1);
        run_pass(-1, 0);
        check("t3_keyon_zero", pass_out[3], 24'h000000);
        run_pass(-1, 0);
        check("t3_after_keyon", pass_out[3], 24'h000100);

        // Wrap-around, carry discarded.
        write_freq(5, 24'hFFFFFF, 1'b0);
        run_pass(-1, 0);
        check("t4_wrap_p1", pass_out[5], 24'hFFFFFF);
        run_pass(-1, 0);
        check("t4_wrap_p2", pass_out[5], 24'hFFFFFE);

        // Write + key-on colliding with voice 7's own update.
        write_freq(7, 24'h000010, 1'b0);
        run_pass(-1, 0);
        check("t5_v7_base", pass_out[7], 24'h000010);
        run_pass(7, 1);
        check("t5_collide_oldfreq", pass_out[7], 24'h000020);
        run_pass(-1, 0);
        check("t5_collide_keyon", pass_out[7], 24'h000000);
        run_pass(-1, 0);
        check("t5_collide_newfreq", pass_out[7], 24'h000020);

        // Overrun: mid-pass tick is ignored, flag is sticky.
        run_pass(10, 2);
        check("t6_valid_cycles", valid_cnt, 32);
        check("t6_busy_cycles",  busy_cnt,  32);
        check("t6_overrun_set",  bus.o_Overrun, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_no_extra_pass", bus.o_Busy, 1'b0);
        check("t6_overrun_sticky", bus.o_Overrun, 1'b1);
        pulse_clear();
        run_pass(20, 3);
        check("t6_set_beats_clear", bus.o_Overrun, 1'b1);
        pulse_clear();
        run_pass(31, 2);
        check("t6_lastvoice_overrun", bus.o_Overrun, 1'b1);
        check("t6_lastvoice_cycles",  valid_cnt, 32);
        check("t6_lastvoice_busy",    busy_cnt,  32);

        // Reset while voice 12 is being processed.
        run_pass(12, 4);
        check("t7_partial_results", valid_cnt, 12);
        check("t7_overrun_reset",   bus.o_Overrun, 1'b0);
        run_pass(-1, 0);
        check("t7_valid_cycles", valid_cnt, 32);
        check("t7_all_zero", count_nonzero_except(-1), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Time-multiplexes one 24-bit phase accumulator across `NUM_VOICES` operator slots. Each voice's frequency word and phase are stored in internal register arrays. On every sample tick the block sweeps all voices in order, one per clock, and advances each phase by its frequency. It streams `(voice, phase)` results to the waveform lookup stage and accepts frequency and key-on writes from the control interface at any time.

## Interface
Parameters:
- `NUM_VOICES`, default 32: number of voice slots. Must be a power of two, ≥2.
- `PHASE_WIDTH`, default 24: width of phase and frequency words.
- `VW` (derived, not overridable) = `$clog2(NUM_VOICES)`.

Ports:
- `i_Clock`  in  1  sole clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_SampleTick`  in  1  one-cycle pulse; starts a pass.
- `i_WriteEnable`  in  1  frequency write strobe.
- `i_WriteVoice`  in  VW  voice addressed by the write.
- `i_WriteFrequency`  in  PHASE_WIDTH  new frequency word, in units of 2^-8 Hz.
- `i_WriteKeyOn`  in  1  with the write: arm a phase clear for that voice.
- `i_ClearOverrun`  in  1  clears `o_Overrun`.
- `o_Busy`  out  1  pass in progress.
- `o_PhaseValid`  out  1  `o_Voice` and `o_Phase` are valid this cycle.
- `o_Voice`  out  VW  voice index of `o_Phase`.
- `o_Phase`  out  PHASE_WIDTH  updated phase of `o_Voice`.
- `o_Overrun`  out  1  sticky: a tick arrived while busy.

## Operation
- Internal state: `freq[NUM_VOICES]`, `phase[NUM_VOICES]`, `pending[NUM_VOICES]` (key-on flags), state IDLE/RUN, voice counter `v`.
- Reset:
  - All `freq`, `phase` and `pending` cleared.
  - State IDLE, `v` = 0.
  - All outputs 0.
- IDLE, `i_SampleTick`=1: go to RUN with `v`=0. IDLE, no tick: hold.
- RUN, each cycle, processing voice `v`:
  - If `pending[v]`: `phase[v]` ← 0 and `pending[v]` ← 0.
  - Otherwise: `phase[v]` ← (`phase[v]` + `freq[v]`) mod 2^PHASE_WIDTH. No saturation; the carry is discarded.
  - Registered outputs: `o_PhaseValid`=1, `o_Voice`=`v`, `o_Phase`=new `phase[v]`.
  - If `v`=`NUM_VOICES`-1: go to IDLE and set `v` ← 0. Otherwise `v` ← `v`+1.
- `o_PhaseValid`=0 on every cycle in which no voice was processed. `o_Voice` and `o_Phase` hold their last values.
- `o_Busy` = (state == RUN).
- `i_SampleTick` while RUN, including during the last-voice cycle:
  - The tick is ignored; no pass is queued.
  - `o_Overrun` ← 1.
- `o_Overrun` priority: a simultaneous `i_ClearOverrun` and overrun event leaves it 1. Otherwise `i_ClearOverrun` clears it. Only reset or `i_ClearOverrun` clears it.
- Writes are accepted in any state, every cycle, with no backpressure:
  - `freq[i_WriteVoice]` ← `i_WriteFrequency`.
  - If `i_WriteKeyOn`: `pending[i_WriteVoice]` ← 1.
- Write/update collision (write addresses the voice being processed that cycle):
  - The update uses the old `freq` and old `pending`.
  - The write is stored afterwards.
  - Net effect: the new frequency and any key-on clear apply on the next pass.
  - A key-on write thus always yields exactly one 0 output on a later pass.
- Reset mid-pass: abort immediately. All arrays are cleared and no further outputs are produced.

## Timing
- Tick sampled at edge T → voice k result registered at edge T+1+k. Observed valid during cycle T+1+k.
- Pass length: `NUM_VOICES` cycles. `o_Busy` is high for exactly `NUM_VOICES` cycles, starting after edge T.
- The earliest accepted next tick is sampled at edge T+`NUM_VOICES`+1. The clock must provide ≥ `NUM_VOICES`+1 cycles per sample period (sample rate 2^16 Hz).
- A write at edge W is visible to any voice update occurring at edge W+1 or later.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then one tick with all frequencies 0:
  - Exactly 32 consecutive valid cycles, voices 0..31, phase 0x000000.
  - `o_Busy` high for 32 cycles; `o_Overrun`=0.
- Write voice 3, freq 0x000100, then 3 ticks:
  - Voice 3 outputs 0x000100, 0x000200, 0x000300.
  - All other voices output 0.
- Wrap-around: voice 5 freq 0xFFFFFF, 2 ticks → outputs 0xFFFFFF, then 0xFFFFFE.
- Key-on: voice 3 at phase 0x000300, write freq 0x000100 with `i_WriteKeyOn` between passes:
  - Next pass: voice 3 = 0x000000.
  - Following pass: voice 3 = 0x000100.
- Collision: voice 7 freq 0x10, write freq 0x20 with key-on in the exact cycle voice 7 is processed:
  - This pass adds 0x10.
  - Next pass: voice 7 = 0.
  - Pass after that adds 0x20.
- Overrun and reset:
  - Tick in cycle 10 of a pass: pass completes unaltered, no extra pass runs.
  - `o_Overrun`=1 until `i_ClearOverrun`.
  - Separately, `i_Reset` at voice 12: `o_PhaseValid`=0 and `o_Busy`=0 from the next cycle. A following pass outputs `freq` = 0 results for all voices.
